// File: rtl/pq_pkg.sv
// Shared types for the priority-queue request scheduler.
package pq_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ID_WIDTH   = 4;

    typedef enum logic [1:0] {
        PQ_OP_PUSH = 2'd0,
        PQ_OP_POP  = 2'd1,
        PQ_OP_DROP = 2'd2,
        PQ_OP_RSVD = 2'd3
    } pq_op_e;

    typedef enum logic [1:0] {
        PQ_ST_OK      = 2'd0,
        PQ_ST_EMPTY   = 2'd1,
        PQ_ST_TIMEOUT = 2'd2,
        PQ_ST_ILLEGAL = 2'd3
    } pq_status_e;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_RESP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pq_rr_arb.sv
// Round-robin arbiter: searches from the last winner + 1 and wraps around,
// so the most recent winner always has the lowest priority.
module pq_rr_arb
    import pq_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       accept_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int GW = $clog2(NUM_REQ);

    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] cand_idx;
    int            cand;

    // Pick the first valid requester after the pointer, wrapping around.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = GW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                idx_o           = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

    // The pointer moves to the winner only when the grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && valid_o) begin
            ptr_d = idx_o;
        end
    end

    // Pointer register; reset value gives requester 0 first priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= GW'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pq_req_sched.sv
// Shares one priority queue between several requesters: arbitrates, issues
// one pq operation per grant with a rdy handshake and watchdog, and returns
// the registered result to the winner.
module pq_req_sched
    import pq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = DATA_WIDTH,
    parameter int IW      = ID_WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*2-1:0]       req_op_i,
    input  logic [NUM_REQ*DW-1:0]      req_data_i,
    input  logic [NUM_REQ*IW-1:0]      req_id_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [DW-1:0]              rsp_data_o,
    output logic [IW-1:0]              rsp_id_o,
    output logic [1:0]                 rsp_status_o,
    output logic                       rsp_ovf_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       pq_push_o,
    output logic                       pq_pop_o,
    output logic                       pq_drop_o,
    output logic [DW-1:0]              pq_data_o,
    output logic [IW-1:0]              pq_drop_id_o,
    input  logic                       pq_push_rdy_i,
    input  logic                       pq_pop_rdy_i,
    input  logic                       pq_drop_rdy_i,
    input  logic [IW-1:0]              pq_push_id_i,
    input  logic [DW-1:0]              pq_data_i,
    input  logic                       pq_empty_i,
    input  logic                       pq_full_i,
    input  logic                       pq_overflow_i
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    sched_state_e  state_q, state_d;
    pq_op_e        op_q, op_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] id_q, id_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    pq_status_e    rsp_status_q, rsp_status_d;
    logic          rsp_ovf_q, rsp_ovf_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [GW-1:0]      arb_idx;
    logic               arb_valid;
    logic               arb_accept;
    pq_op_e             sel_op;
    logic [DW-1:0]      sel_data;
    logic [IW-1:0]      sel_id;
    logic               issue;
    logic               fire;

    // A full pq still accepts pushes (it evicts), so fullness is not consulted.
    logic unused_full;
    assign unused_full = pq_full_i;

    assign arb_accept = (state_q == SCHED_IDLE) && arb_valid;

    pq_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_valid_i),
        .accept_i (arb_accept),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx),
        .valid_o  (arb_valid)
    );

    // One-hot mux of the winning requester's op, data and id.
    always_comb begin
        sel_op   = PQ_OP_PUSH;
        sel_data = '0;
        sel_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_op   = pq_op_e'(req_op_i[k*2 +: 2]);
                sel_data = req_data_i[k*DW +: DW];
                sel_id   = req_id_i[k*IW +: IW];
            end
        end
    end

    // Strobes come straight from the state register so reset drops them at once.
    assign issue        = (state_q == SCHED_ISSUE);
    assign pq_push_o    = issue && (op_q == PQ_OP_PUSH);
    assign pq_pop_o     = issue && (op_q == PQ_OP_POP);
    assign pq_drop_o    = issue && (op_q == PQ_OP_DROP);
    assign fire         = (pq_push_o && pq_push_rdy_i) ||
                          (pq_pop_o  && pq_pop_rdy_i)  ||
                          (pq_drop_o && pq_drop_rdy_i);
    assign pq_data_o    = data_q;
    assign pq_drop_id_o = id_q;

    assign req_ready_o  = (rst_ni && arb_accept) ? arb_gnt : '0;
    assign busy_o       = (state_q != SCHED_IDLE);
    assign grant_idx_o  = grant_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_status_o = rsp_status_q;
    assign rsp_ovf_o    = rsp_ovf_q;

    // Only the granted requester sees a response valid.
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == SCHED_RESP) begin
            rsp_valid_o[grant_q] = 1'b1;
        end
    end

    // Scheduler next-state: accept, issue with watchdog, hold response.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        id_d         = id_q;
        grant_d      = grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_status_d = rsp_status_q;
        rsp_ovf_d    = rsp_ovf_q;
        wd_cnt_d     = wd_cnt_q;
        case (state_q)
            SCHED_IDLE: begin
                if (arb_valid) begin
                    op_d     = sel_op;
                    data_d   = sel_data;
                    id_d     = sel_id;
                    grant_d  = arb_idx;
                    wd_cnt_d = '0;
                    if (sel_op == PQ_OP_RSVD) begin
                        state_d      = SCHED_RESP;
                        rsp_status_d = PQ_ST_ILLEGAL;
                    end else if (sel_op == PQ_OP_POP && pq_empty_i) begin
                        state_d      = SCHED_RESP;
                        rsp_status_d = PQ_ST_EMPTY;
                    end else begin
                        state_d = SCHED_ISSUE;
                    end
                end
            end
            SCHED_ISSUE: begin
                if (fire) begin
                    state_d      = SCHED_RESP;
                    rsp_status_d = PQ_ST_OK;
                    wd_cnt_d     = '0;
                    case (op_q)
                        PQ_OP_PUSH: begin
                            rsp_id_d   = pq_push_id_i;
                            rsp_data_d = data_q;
                            rsp_ovf_d  = pq_overflow_i;
                        end
                        PQ_OP_POP: begin
                            rsp_id_d   = '0;
                            rsp_data_d = pq_data_i;
                        end
                        PQ_OP_DROP: begin
                            rsp_id_d   = id_q;
                            rsp_data_d = '0;
                        end
                        default: begin
                            rsp_id_d   = '0;
                            rsp_data_d = '0;
                        end
                    endcase
                end else if (TIMEOUT != 0 && wd_cnt_q == WD_LAST) begin
                    state_d      = SCHED_RESP;
                    rsp_status_d = PQ_ST_TIMEOUT;
                    rsp_data_d   = '0;
                    rsp_id_d     = '0;
                    rsp_ovf_d    = 1'b0;
                    wd_cnt_d     = '0;
                end else if (TIMEOUT != 0) begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            SCHED_RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    state_d      = SCHED_IDLE;
                    rsp_data_d   = '0;
                    rsp_id_d     = '0;
                    rsp_status_d = PQ_ST_OK;
                    rsp_ovf_d    = 1'b0;
                end
            end
            default: begin
                state_d = SCHED_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= SCHED_IDLE;
            op_q         <= PQ_OP_PUSH;
            data_q       <= '0;
            id_q         <= '0;
            grant_q      <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_status_q <= PQ_ST_OK;
            rsp_ovf_q    <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            id_q         <= id_d;
            grant_q      <= grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_status_q <= rsp_status_d;
            rsp_ovf_q    <= rsp_ovf_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_pq_req_sched.sv
// Bench for pq_req_sched: directed steps followed by random traffic, with a
// small behavioural priority queue (smallest data first) standing in for pq.
module tb_pq_req_sched;
    import pq_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int IW      = 4;
    localparam int TIMEOUT = 16;
    localparam int CAP     = 4;

    logic                  clk;
    logic                  rst_ni;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*2-1:0]  req_op_i;
    logic [NUM_REQ*DW-1:0] req_data_i;
    logic [NUM_REQ*IW-1:0] req_id_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [NUM_REQ-1:0]    rsp_ready_i;
    logic [DW-1:0]         rsp_data_o;
    logic [IW-1:0]         rsp_id_o;
    logic [1:0]            rsp_status_o;
    logic                  rsp_ovf_o;
    logic                  busy_o;
    logic [1:0]            grant_idx_o;
    logic                  pq_push_o, pq_pop_o, pq_drop_o;
    logic [DW-1:0]         pq_data_o;
    logic [IW-1:0]         pq_drop_id_o;
    logic                  pq_push_rdy_i, pq_pop_rdy_i, pq_drop_rdy_i;
    logic [IW-1:0]         pq_push_id_i;
    logic [DW-1:0]         pq_data_i;
    logic                  pq_empty_i, pq_full_i, pq_overflow_i;

    pq_req_sched #(
        .NUM_REQ (NUM_REQ),
        .DW      (DW),
        .IW      (IW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_data_i    (req_data_i),
        .req_id_i      (req_id_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_id_o      (rsp_id_o),
        .rsp_status_o  (rsp_status_o),
        .rsp_ovf_o     (rsp_ovf_o),
        .busy_o        (busy_o),
        .grant_idx_o   (grant_idx_o),
        .pq_push_o     (pq_push_o),
        .pq_pop_o      (pq_pop_o),
        .pq_drop_o     (pq_drop_o),
        .pq_data_o     (pq_data_o),
        .pq_drop_id_o  (pq_drop_id_o),
        .pq_push_rdy_i (pq_push_rdy_i),
        .pq_pop_rdy_i  (pq_pop_rdy_i),
        .pq_drop_rdy_i (pq_drop_rdy_i),
        .pq_push_id_i  (pq_push_id_i),
        .pq_data_i     (pq_data_i),
        .pq_empty_i    (pq_empty_i),
        .pq_full_i     (pq_full_i),
        .pq_overflow_i (pq_overflow_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } ent_t;

    ent_t               pq_q[$];
    logic [IW-1:0]      next_id;
    logic [NUM_REQ-1:0] pend;
    int                 last_g;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int minIdx();
        int m = 0;
        for (int i = 1; i < pq_q.size(); i++) if (pq_q[i].data < pq_q[m].data) m = i;
        return m;
    endfunction

    function automatic int maxIdx();
        int m = 0;
        for (int i = 1; i < pq_q.size(); i++) if (pq_q[i].data > pq_q[m].data) m = i;
        return m;
    endfunction

    task automatic driveModel();
        pq_empty_i    = (pq_q.size() == 0);
        pq_full_i     = (pq_q.size() >= CAP);
        pq_overflow_i = pq_full_i;
        pq_push_id_i  = next_id;
        pq_data_i     = pq_empty_i ? '0 : pq_q[minIdx()].data;
    endtask

    // Round-robin choice stated directly: first pending index after the last winner.
    function automatic int rrPick(input logic [NUM_REQ-1:0] p, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (p[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Advance one clock; the pq model reacts to accepted strobes.
    task automatic tick();
        logic          fp, fo, fd;
        logic [DW-1:0] pd;
        logic [IW-1:0] did;
        ent_t          e;
        checkOutput("ready_at_most_one", 32'($countones(req_ready_o) <= 1), 1);
        fp  = pq_push_o && pq_push_rdy_i;
        fo  = pq_pop_o && pq_pop_rdy_i;
        fd  = pq_drop_o && pq_drop_rdy_i;
        pd  = pq_data_o;
        did = pq_drop_id_o;
        @(posedge clk);
        #1;
        if (fp) begin
            if (pq_q.size() >= CAP) pq_q.delete(maxIdx());
            e.data = pd;
            e.id   = next_id;
            pq_q.push_back(e);
            next_id = next_id + 1'b1;
        end
        if (fo && pq_q.size() > 0) pq_q.delete(minIdx());
        if (fd) begin
            for (int i = 0; i < pq_q.size(); i++) begin
                if (pq_q[i].id == did) begin
                    pq_q.delete(i);
                    break;
                end
            end
        end
        driveModel();
    endtask

    task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [DW-1:0] d,
                                 input logic [IW-1:0] id);
        pend[idx]              = 1'b1;
        req_valid_i[idx]       = 1'b1;
        req_op_i[idx*2 +: 2]   = op;
        req_data_i[idx*DW +: DW] = d;
        req_id_i[idx*IW +: IW] = id;
    endtask

    task automatic doReset();
        rst_ni        = 1'b0;
        pend          = '0;
        req_op_i      = '0;
        req_data_i    = '0;
        req_id_i      = '0;
        rsp_ready_i   = '0;
        pq_push_rdy_i = 1'b0;
        pq_pop_rdy_i  = 1'b0;
        pq_drop_rdy_i = 1'b0;
        pq_q.delete();
        next_id       = '0;
        last_g        = NUM_REQ - 1;
        driveModel();
        req_valid_i   = '1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", req_ready_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_grant_idx", grant_idx_o, 0);
        checkOutput("rst_strobes", {pq_push_o, pq_pop_o, pq_drop_o}, 0);
        checkOutput("rst_rsp_fields", {rsp_data_o, rsp_id_o, rsp_status_o, rsp_ovf_o}, 0);
        checkOutput("rst_pq_out", {pq_data_o, pq_drop_id_o}, 0);
        req_valid_i = '0;
        rst_ni      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Serve the next request the round-robin rule selects, checking every phase.
    task automatic serviceNext(input int rdy_delay, input int rsp_delay);
        int               g, strobes, cyc, exp_strobes;
        logic [1:0]       op;
        logic [DW-1:0]    gd, exp_data;
        logic [IW-1:0]    gid, exp_id;
        pq_status_e       exp_st;
        logic             exp_ovf;
        logic [NUM_REQ-1:0] onehot;
        logic [2:0]       exp_strb;
        #1;
        g = rrPick(pend, last_g);
        if (g < 0) return;
        onehot = '0;
        onehot[g] = 1'b1;
        checkOutput("req_ready", req_ready_o, onehot);
        checkOutput("busy_idle", busy_o, 0);
        op  = req_op_i[g*2 +: 2];
        gd  = req_data_i[g*DW +: DW];
        gid = req_id_i[g*IW +: IW];
        exp_data = '0; exp_id = '0; exp_ovf = 1'b0; exp_strobes = 0;
        exp_strb = (op == PQ_OP_PUSH) ? 3'b100 : (op == PQ_OP_POP) ? 3'b010 : 3'b001;
        if (op == PQ_OP_RSVD) exp_st = PQ_ST_ILLEGAL;
        else if (op == PQ_OP_POP && pq_q.size() == 0) exp_st = PQ_ST_EMPTY;
        else begin
            exp_strobes = (rdy_delay < TIMEOUT) ? rdy_delay + 1 : TIMEOUT;
            if (rdy_delay >= TIMEOUT) exp_st = PQ_ST_TIMEOUT;
            else begin
                exp_st = PQ_ST_OK;
                if (op == PQ_OP_PUSH) begin
                    exp_data = gd;
                    exp_id   = next_id;
                    exp_ovf  = (pq_q.size() >= CAP);
                end else if (op == PQ_OP_POP) begin
                    exp_data = pq_q[minIdx()].data;
                end else begin
                    exp_id = gid;
                end
            end
        end
        pq_push_rdy_i = (op != PQ_OP_PUSH);
        pq_pop_rdy_i  = (op != PQ_OP_POP);
        pq_drop_rdy_i = (op != PQ_OP_DROP);
        tick();
        pend[g]        = 1'b0;
        req_valid_i[g] = 1'b0;
        last_g         = g;
        checkOutput("grant_idx", grant_idx_o, g);
        strobes = 0;
        cyc     = 0;
        while (rsp_valid_o == '0 && cyc < 40) begin
            checkOutput("strobe_sel", {pq_push_o, pq_pop_o, pq_drop_o}, exp_strb);
            checkOutput("ready_in_issue", req_ready_o, 0);
            if (op == PQ_OP_PUSH) checkOutput("pq_data_out", pq_data_o, gd);
            if (op == PQ_OP_DROP) checkOutput("pq_drop_id_out", pq_drop_id_o, gid);
            if (op == PQ_OP_PUSH) pq_push_rdy_i = (strobes >= rdy_delay);
            if (op == PQ_OP_POP)  pq_pop_rdy_i  = (strobes >= rdy_delay);
            if (op == PQ_OP_DROP) pq_drop_rdy_i = (strobes >= rdy_delay);
            strobes++;
            cyc++;
            tick();
        end
        checkOutput("strobe_cycles", strobes, exp_strobes);
        if (op == PQ_OP_PUSH) pq_push_rdy_i = 1'b0;
        if (op == PQ_OP_POP)  pq_pop_rdy_i  = 1'b0;
        if (op == PQ_OP_DROP) pq_drop_rdy_i = 1'b0;
        rsp_ready_i = ~onehot;
        for (int i = 0; i <= rsp_delay; i++) begin
            if (i > 0) tick();
            checkOutput("rsp_valid", rsp_valid_o, onehot);
            checkOutput("rsp_status", rsp_status_o, exp_st);
            checkOutput("rsp_data", rsp_data_o, exp_data);
            checkOutput("rsp_id", rsp_id_o, exp_id);
            checkOutput("rsp_ovf", rsp_ovf_o, exp_ovf);
            checkOutput("resp_strobes_off", {pq_push_o, pq_pop_o, pq_drop_o}, 0);
            checkOutput("resp_busy", busy_o, 1);
            checkOutput("resp_no_ready", req_ready_o, 0);
        end
        rsp_ready_i = onehot;
        tick();
        rsp_ready_i = '0;
        checkOutput("rsp_valid_clear", rsp_valid_o, 0);
        checkOutput("rsp_fields_clear", {rsp_data_o, rsp_id_o, rsp_status_o, rsp_ovf_o}, 0);
        checkOutput("idle_busy", busy_o, 0);
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout observed=stalled expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int            r;
        int            delays[9];
        logic [1:0]    rop;
        delays = '{0, 0, 0, 1, 2, 3, 15, 16, 20};

        doReset();

        // Pop from an empty queue: no strobe, EMPTY one cycle after accept.
        applyStimulus(1, PQ_OP_POP, 8'h00, 4'h0);
        serviceNext(0, 0);

        // Single push with immediate rdy.
        applyStimulus(0, PQ_OP_PUSH, 8'hF0, 4'h0);
        serviceNext(0, 0);

        // All four requesters after reset: grants 0,1,2,3.
        doReset();
        applyStimulus(0, PQ_OP_PUSH, 8'h15, 4'h0);
        applyStimulus(1, PQ_OP_PUSH, 8'h87, 4'h0);
        applyStimulus(2, PQ_OP_POP,  8'h00, 4'h0);
        applyStimulus(3, PQ_OP_DROP, 8'h00, 4'h3);
        serviceNext(0, 0);
        serviceNext(1, 0);
        serviceNext(2, 0);
        serviceNext(0, 0);

        // Re-requests from 0 and 2 after 3 won: 0 then 2.
        applyStimulus(0, PQ_OP_PUSH, 8'h40, 4'h0);
        applyStimulus(2, PQ_OP_PUSH, 8'h22, 4'h0);
        serviceNext(0, 0);
        serviceNext(0, 0);

        // Pop that never sees rdy times out; pending req2 follows.
        applyStimulus(0, PQ_OP_POP,  8'h00, 4'h0);
        applyStimulus(2, PQ_OP_PUSH, 8'h33, 4'h0);
        serviceNext(100, 1);
        serviceNext(0, 0);

        // Reserved op from req3 with response held off while req1 waits.
        applyStimulus(3, PQ_OP_RSVD, 8'hAA, 4'h5);
        applyStimulus(1, PQ_OP_PUSH, 8'h09, 4'h0);
        serviceNext(0, 5);
        serviceNext(0, 0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    r   = $urandom_range(0, 9);
                    rop = (r < 5) ? PQ_OP_PUSH : (r < 7) ? PQ_OP_POP : (r < 9) ? PQ_OP_DROP : PQ_OP_RSVD;
                    applyStimulus(i, rop, 8'($urandom), 4'($urandom_range(0, 15)));
                end
            end
            if (pend == '0) applyStimulus(0, PQ_OP_PUSH, 8'($urandom), 4'h0);
            serviceNext(delays[$urandom_range(0, 8)], $urandom_range(0, 2));
        end
        for (int n = 0; n < NUM_REQ && pend != '0; n++) serviceNext(0, 0);

        // Reset during ISSUE drops the strobe immediately.
        applyStimulus(2, PQ_OP_PUSH, 8'h5A, 4'h0);
        pq_push_rdy_i = 1'b0;
        #1;
        tick();
        pend[2]        = 1'b0;
        req_valid_i[2] = 1'b0;
        checkOutput("issue_before_reset", pq_push_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("reset_drops_strobe", pq_push_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_rsp_valid", rsp_valid_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pq_req_sched.md
Name: pq_req_sched

Overview:
- Shares one `pq` instance between NUM_REQ independent requesters. Each requester issues push, pop or drop operations over a valid/ready request channel and receives a result on a valid/ready response channel.
- Round-robin arbitration picks one requester at a time. The block drives the pq op strobe with the pq's hold-until-rdy handshake, then returns the result (assigned id, popped data, status) to the winner.
- Sits between client logic (e.g. interrupt or task sources) and the pq datapath.

Parameters:
- NUM_REQ, 4, number of requesters (>=2); GW = $clog2(NUM_REQ).
- DW, DATA_WIDTH, pq data width.
- IW, ID_WIDTH, pq id width.
- TIMEOUT, 16, max ISSUE cycles waiting for pq rdy; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester request accepted
- req_op_i  in  NUM_REQ*2  per-requester op (pq_op_e)
- req_data_i  in  NUM_REQ*DW  per-requester push data
- req_id_i  in  NUM_REQ*IW  per-requester drop id
- rsp_valid_o  out  NUM_REQ  response valid, only the granted requester's bit
- rsp_ready_i  in  NUM_REQ  response accept
- rsp_data_o  out  DW  pushed data echo or popped data
- rsp_id_o  out  IW  push: assigned id; drop: dropped id; pop: 0
- rsp_status_o  out  2  pq_status_e
- rsp_ovf_o  out  1  push caused pq overflow
- busy_o  out  1  state != IDLE
- grant_idx_o  out  GW  index of current or last granted requester
- pq_push_o / pq_pop_o / pq_drop_o  out  1 each  pq op strobes
- pq_data_o  out  DW  pq push data
- pq_drop_id_o  out  IW  pq drop id
- pq_push_rdy_i / pq_pop_rdy_i / pq_drop_rdy_i  in  1 each  pq op ready
- pq_push_id_i  in  IW  id assigned by pq
- pq_data_i  in  DW  pq head data
- pq_empty_i, pq_full_i, pq_overflow_i  in  1 each  pq status

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer set so requester 0 has first priority, watchdog counter 0. Reset mid-operation drops the pq strobe immediately and abandons the operation with no response.
- Op encoding: PUSH=0, POP=1, DROP=2, RSVD=3. Status encoding: OK=0, EMPTY=1, TIMEOUT=2, ILLEGAL=3.
- Request rule: req_valid_i must be held with its fields stable until req_ready_o is seen (not checked).
- IDLE:
  - The RR arbiter picks a winner g among valid requests, searching g_last+1 ... g_last.
  - req_ready_o[g]=1 combinationally in the same cycle; at most one ready bit per cycle, never outside IDLE.
  - On that edge, latch op, data and id; set grant_idx_o=g; the pointer becomes g.
  - Next state: RSVD -> RESP with ILLEGAL; POP with pq_empty_i=1 -> RESP with EMPTY, no strobe issued; otherwise -> ISSUE.
- ISSUE:
  - The strobe matching the op is high; pq_data_o and pq_drop_id_o are driven from the latched registers.
  - On the edge where strobe && matching rdy, capture the result and go to RESP with OK:
    - push: rsp_id=pq_push_id_i, rsp_data=latched data, rsp_ovf=pq_overflow_i;
    - pop: rsp_data=pq_data_i, rsp_id=0;
    - drop: rsp_id=latched id.
  - The strobe is low from the next cycle, i.e. exactly one accepted op per grant.
  - Watchdog: counts ISSUE cycles. If TIMEOUT!=0 and the count reaches TIMEOUT with no rdy, the strobe is dropped and the block goes to RESP with TIMEOUT, data and id 0.
- RESP:
  - rsp_valid_o[g]=1 with all rsp fields registered and stable.
  - On rsp_ready_i[g] -> IDLE, and rsp fields clear to 0.
  - No arbitration while in RESP, so minimum service time is 3 cycles (accept, issue+rdy, resp).
- pq_full_i does not block pushes; the pq evicts the lowest-priority entry and the block reports it via rsp_ovf_o.
- A request arriving from the winner again in IDLE has lowest priority if others are valid.

Decomposition:
- pq_pkg gains pq_op_e, pq_status_e and the sched_state_e typedef (IDLE/ISSUE/RESP).
- Sub-module pq_rr_arb (NUM_REQ): request vector in, one-hot grant plus index out, pointer register updated on an accept strobe.

Test Plan:
- req0 PUSH 0xF0, pq push_rdy=1 -> ready0 in cycle 0, pq_push_o high in cycle 1 only, rsp_valid0 in cycle 2 with OK, rsp_data=0xF0, rsp_id=pq_push_id_i.
- All 4 requesters valid after reset, rsp_ready=1 -> grants 0,1,2,3 in order; then req0 and req2 re-request -> 0 then 2.
- req1 POP with pq_empty_i=1 -> no pq_pop_o pulse, rsp_valid1 one cycle after accept with EMPTY.
- PUSH 0x15, PUSH 0x87 into a pq model, then POP -> rsp_data=0x15, status OK; DROP id 3 -> pq_drop_id_o=3, rsp_id=3.
- TIMEOUT=16, pq_pop_rdy_i held 0 -> pq_pop_o high exactly 16 cycles, then TIMEOUT status; a pending req2 is served next.
- req3 op=3 -> ILLEGAL, no strobe; rsp_ready3 held 0 for 5 cycles -> rsp fields stable, busy_o=1, no req_ready_o asserted.
